// File: rtl/uart_tx_param_if.sv
// Word handshake between the system data path and the UART transmitter.
// The master offers data_in/tx_valid; the transmitter answers with tx_ready.
`timescale 1ns/1ps
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output data_in,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  data_in,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding buffer.
// Frame: start, DATA_W data bits, optional parity, 1 or 2 stop bits.
`timescale 1ns/1ps
module uart_tx_param #(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic            clk_50m,
    input  logic            rst,
    input  logic            clken,
    uart_tx_param_if.slave  tx_if,
    output logic            Tx,
    output logic            Tx_busy,
    output logic            tx_done
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] word_q,  word_d;
    logic [DATA_W-1:0] hold_q,  hold_d;
    logic              hold_full_q, hold_full_d;
    logic              ready_q, ready_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic accept;
    logic bit_last;
    logic stop_last;
    logic par_bit;

    assign accept    = tx_if.tx_valid && ready_q;
    assign bit_last  = (bit_cnt_q == CW'(DATA_W - 1));
    assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_cnt_q;
    assign par_bit   = (PARITY == 2) ? ~^word_q : ^word_q;

    assign Tx             = tx_q;
    assign tx_done        = done_q;
    assign tx_if.tx_ready = ready_q;
    assign Tx_busy        = (state_q != S_IDLE);

    // Next-state logic: buffer accept/transfer and per-bit line updates
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        word_d      = word_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        tx_d        = tx_q;
        done_d      = 1'b0;

        // ready_q is ~hold_full_q, so accept never meets a transfer
        if (accept) begin
            hold_d      = tx_if.data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    word_d      = hold_q;
                    bit_cnt_d   = '0;
                    hold_full_d = 1'b0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (clken) begin
                    tx_d    = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (clken) begin
                    if (LSB_FIRST != 0) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else begin
                        tx_d    = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_last) begin
                        stop_cnt_d = 1'b0;
                        state_d    = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (clken) begin
                    tx_d       = par_bit;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (clken) begin
                    tx_d = 1'b1;
                    if (stop_last) begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            word_d      = hold_q;
                            bit_cnt_d   = '0;
                            hold_full_d = 1'b0;
                            state_d     = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        ready_d = ~hold_full_d;
    end

    // State register with synchronous reset that abandons any frame
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            word_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end
endmodule
